// File: rtl/boot_sequencer_if.sv
// ioctl download bus from data_io together with the ROM write port toward the arcade core.
// master = data_io/core side, slave = boot_sequencer.
interface boot_sequencer_if;
    logic        ioctl_downl;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;

    modport master (
        output ioctl_downl, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr
    );

    modport slave (
        input  ioctl_downl, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr
    );
endinterface

// File: rtl/boot_sequencer.sv
// Boot sequencer: routes ioctl downloads to the ROM loader / DIP defaults and sequences core reset.
// Optional macro BOOT_CHECKSUM_EN: a full-length image must also sum to EXPECTED_SUM.
module boot_sequencer #(
    parameter int unsigned ROM_BYTES    = 49152,
    parameter int unsigned HOLD_PULSES  = 16,
    parameter logic [31:0] DIP_DEFAULT  = 32'hFFFF_FFFF,
    parameter logic [15:0] EXPECTED_SUM = 16'h0000
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            ce_6m,
    input  logic            user_reset,
    boot_sequencer_if.slave io,
    output logic [31:0]     dip_defaults,
    output logic            core_reset,
    output logic            rom_loaded,
    output logic            boot_error,
    output logic            busy,
    output logic [15:0]     checksum
);
    localparam int unsigned       HOLD_W    = (HOLD_PULSES > 1) ? $clog2(HOLD_PULSES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PULSES - 1);
    localparam logic [24:0]       ROM_LIMIT = 25'(ROM_BYTES);
    localparam logic [16:0]       CNT_MIN   = 17'(ROM_BYTES);
    localparam logic [16:0]       CNT_MAX   = 17'h1FFFF;

    typedef enum logic [2:0] {
        ST_NOROM   = 3'd0,
        ST_LOADING = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RUN     = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [7:0]        index_r;
    logic [16:0]       byte_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              hold_clr_s;
    logic              hold_inc_s;
    logic              loading_s;
    logic              start_s;
    logic              start0_s;
    logic              leave0_s;
    logic              wr0_s;
    logic              wr1_s;
    logic              len_ok_s;
    logic              sum_ok_s;

    assign loading_s = (state_r == ST_LOADING);
    assign start_s   = io.ioctl_downl && !loading_s;
    assign start0_s  = start_s && (io.ioctl_index == 8'd0);
    // Inside LOADING the strobe only ever drops once, so a low downl here is the falling edge.
    assign leave0_s  = loading_s && !io.ioctl_downl && (index_r == 8'd0);
    assign wr0_s     = loading_s && io.ioctl_wr && (index_r == 8'd0) && (io.ioctl_addr < ROM_LIMIT);
    assign wr1_s     = loading_s && io.ioctl_wr && (index_r == 8'd1) && (io.ioctl_addr < 25'd4);
    assign len_ok_s  = (byte_cnt_r >= CNT_MIN);

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r <= ST_NOROM;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and hold-counter control; a new download overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        hold_clr_s  = 1'b0;
        hold_inc_s  = 1'b0;
        if (start_s) begin
            state_nxt_s = ST_LOADING;
        end else begin
            case (state_r)
                ST_LOADING: begin
                    if (!io.ioctl_downl) begin
                        hold_clr_s = 1'b1;
                        if (index_r == 8'd0) begin
                            if (len_ok_s && sum_ok_s) begin
                                state_nxt_s = ST_HOLD;
                            end else begin
                                state_nxt_s = ST_ERROR;
                            end
                        end else if (rom_loaded) begin
                            state_nxt_s = ST_HOLD;
                        end else if (boot_error) begin
                            state_nxt_s = ST_ERROR;
                        end else begin
                            state_nxt_s = ST_NOROM;
                        end
                    end else begin
                        state_nxt_s = ST_LOADING;
                    end
                end
                ST_HOLD: begin
                    if (user_reset) begin
                        hold_clr_s = 1'b1;
                    end else if (ce_6m && (hold_cnt_r == HOLD_LAST)) begin
                        state_nxt_s = ST_RUN;
                        hold_clr_s  = 1'b1;
                    end else if (ce_6m) begin
                        hold_inc_s = 1'b1;
                    end else begin
                        hold_inc_s = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (user_reset) begin
                        state_nxt_s = ST_HOLD;
                        hold_clr_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                default: begin
                    state_nxt_s = state_r;
                end
            endcase
        end
    end

    // Hold counter: ce_6m pulses seen while core reset is being held.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hold_cnt_r <= '0;
        end else if (hold_clr_s) begin
            hold_cnt_r <= '0;
        end else if (hold_inc_s) begin
            hold_cnt_r <= hold_cnt_r + 1'b1;
        end
    end

    // Status outputs, byte counter and latched download index.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            core_reset <= 1'b1;
            busy       <= 1'b0;
            rom_loaded <= 1'b0;
            boot_error <= 1'b0;
            index_r    <= 8'd0;
            byte_cnt_r <= 17'd0;
        end else begin
            core_reset <= (state_nxt_s != ST_RUN);
            busy       <= (state_nxt_s == ST_LOADING) || (state_nxt_s == ST_HOLD);
            if (start_s) begin
                index_r <= io.ioctl_index;
            end
            if (start0_s) begin
                byte_cnt_r <= 17'd0;
                rom_loaded <= 1'b0;
            end else if (leave0_s) begin
                rom_loaded <= len_ok_s && sum_ok_s;
                boot_error <= !(len_ok_s && sum_ok_s);
            end else if (wr0_s && (byte_cnt_r != CNT_MAX)) begin
                byte_cnt_r <= byte_cnt_r + 17'd1;
            end
        end
    end

    // ROM loader port: accepted index-0 bytes forwarded one cycle later.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            io.dn_wr   <= 1'b0;
            io.dn_addr <= 16'd0;
            io.dn_data <= 8'd0;
        end else begin
            io.dn_wr <= wr0_s;
            if (wr0_s) begin
                io.dn_addr <= io.ioctl_addr[15:0];
                io.dn_data <= io.ioctl_dout;
            end
        end
    end

    // DIP defaults: index-1 bytes 0..3, byte 0 in the low bits.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dip_defaults <= DIP_DEFAULT;
        end else if (wr1_s) begin
            case (io.ioctl_addr[1:0])
                2'd0:    dip_defaults[7:0]   <= io.ioctl_dout;
                2'd1:    dip_defaults[15:8]  <= io.ioctl_dout;
                2'd2:    dip_defaults[23:16] <= io.ioctl_dout;
                2'd3:    dip_defaults[31:24] <= io.ioctl_dout;
                default: dip_defaults        <= dip_defaults;
            endcase
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic [15:0] sum_r;

    // Running byte sum of accepted index-0 bytes, modulo 2^16.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sum_r <= 16'd0;
        end else if (start0_s) begin
            sum_r <= 16'd0;
        end else if (wr0_s) begin
            sum_r <= sum_r + {8'd0, io.ioctl_dout};
        end
    end

    assign sum_ok_s = (sum_r == EXPECTED_SUM);
    assign checksum = sum_r;
`else
    logic [15:0] unused_expected_sum_s;

    assign unused_expected_sum_s = EXPECTED_SUM;
    assign sum_ok_s = 1'b1;
    assign checksum = 16'd0;
`endif
endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: directed sequences, a DIP vector table and
// randomized downloads checked every cycle against an event-level reference model.
module tb_boot_sequencer;
    localparam int unsigned ROM_BYTES   = 49152;
    localparam int unsigned HOLD_PULSES = 16;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [15:0] EXP_SUM = 16'hA000;
`else
    localparam logic [15:0] EXP_SUM = 16'h0000;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_6m;
    logic        user_reset;
    logic [31:0] dip_defaults;
    logic        core_reset;
    logic        rom_loaded;
    logic        boot_error;
    logic        busy;
    logic [15:0] checksum;

    boot_sequencer_if bus();

    always #5 clk_sys = ~clk_sys;

    boot_sequencer #(
        .ROM_BYTES   (ROM_BYTES),
        .HOLD_PULSES (HOLD_PULSES),
        .DIP_DEFAULT (32'hFFFF_FFFF),
        .EXPECTED_SUM(EXP_SUM)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ce_6m       (ce_6m),
        .user_reset  (user_reset),
        .io          (bus.slave),
        .dip_defaults(dip_defaults),
        .core_reset  (core_reset),
        .rom_loaded  (rom_loaded),
        .boot_error  (boot_error),
        .busy        (busy),
        .checksum    (checksum)
    );

`ifdef BOOT_CHECKSUM_EN
    // Second instance sees the same download with an image whose sum is 16'h1235.
    logic [31:0] dip_c;
    logic        core_reset_c, rom_loaded_c, boot_error_c, busy_c;
    logic [15:0] checksum_c;
    boot_sequencer_if bus_c();
    assign bus_c.ioctl_downl = bus.ioctl_downl;
    assign bus_c.ioctl_index = bus.ioctl_index;
    assign bus_c.ioctl_wr    = bus.ioctl_wr;
    assign bus_c.ioctl_addr  = bus.ioctl_addr;
    assign bus_c.ioctl_dout  = (bus.ioctl_addr < 25'd18) ? 8'hFF :
                               (bus.ioctl_addr == 25'd18) ? 8'h47 : 8'h00;

    boot_sequencer #(
        .ROM_BYTES   (ROM_BYTES),
        .HOLD_PULSES (HOLD_PULSES),
        .DIP_DEFAULT (32'hFFFF_FFFF),
        .EXPECTED_SUM(16'h1234)
    ) dut_chk (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ce_6m       (ce_6m),
        .user_reset  (user_reset),
        .io          (bus_c.slave),
        .dip_defaults(dip_c),
        .core_reset  (core_reset_c),
        .rom_loaded  (rom_loaded_c),
        .boot_error  (boot_error_c),
        .busy        (busy_c),
        .checksum    (checksum_c)
    );
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_dnwr = 0;
    int tick = 0;
    int ce_period = 4;

    // Reference model: download in progress, loaded/error flags, countdown of hold pulses.
    bit          m_dl, m_loaded, m_err, m_run, m_dn_wr;
    logic [7:0]  m_idx;
    int          m_cnt, m_left;
    logic [15:0] m_sum, m_dn_addr;
    logic [7:0]  m_dn_data;
    logic [31:0] m_dip;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [31:0] exp_dip;
    } dip_vec_t;

    dip_vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_dl = 1'b0; m_loaded = 1'b0; m_err = 1'b0; m_run = 1'b0; m_dn_wr = 1'b0;
        m_idx = 8'd0; m_cnt = 0; m_left = 0; m_sum = 16'd0;
        m_dn_addr = 16'd0; m_dn_data = 8'd0; m_dip = 32'hFFFF_FFFF;
    endfunction

    function automatic void model_step();
        bit sum_ok;
`ifdef BOOT_CHECKSUM_EN
        sum_ok = (m_sum == EXP_SUM);
`else
        sum_ok = 1'b1;
`endif
        m_dn_wr = 1'b0;
        if (bus.ioctl_downl && !m_dl) begin
            m_dl = 1'b1; m_idx = bus.ioctl_index; m_run = 1'b0; m_left = 0;
            if (m_idx == 8'd0) begin
                m_cnt = 0; m_sum = 16'd0; m_loaded = 1'b0;
            end
        end else if (m_dl) begin
            if (!bus.ioctl_downl) begin
                m_dl = 1'b0;
                if (m_idx == 8'd0) begin
                    if (m_cnt >= int'(ROM_BYTES) && sum_ok) begin
                        m_loaded = 1'b1; m_err = 1'b0; m_left = HOLD_PULSES;
                    end else begin
                        m_loaded = 1'b0; m_err = 1'b1;
                    end
                end else if (m_loaded) begin
                    m_left = HOLD_PULSES;
                end
            end else if (bus.ioctl_wr) begin
                if (m_idx == 8'd0 && bus.ioctl_addr < ROM_BYTES) begin
                    m_dn_wr = 1'b1; m_dn_addr = bus.ioctl_addr[15:0]; m_dn_data = bus.ioctl_dout;
                    if (m_cnt < 131071) m_cnt++;
                    m_sum = m_sum + 16'(bus.ioctl_dout);
                end else if (m_idx == 8'd1 && bus.ioctl_addr < 4) begin
                    m_dip[8*int'(bus.ioctl_addr[1:0]) +: 8] = bus.ioctl_dout;
                end
            end
        end else if (m_left > 0) begin
            if (user_reset) begin
                m_left = HOLD_PULSES;
            end else if (ce_6m) begin
                m_left--;
                if (m_left == 0) m_run = 1'b1;
            end
        end else if (m_run && user_reset) begin
            m_run = 1'b0; m_left = HOLD_PULSES;
        end
    endfunction

    task automatic model_check();
        if (bus.dn_wr === 1'b1) n_dnwr++;
        check("core_reset", core_reset, !m_run);
        check("busy", busy, (m_dl || m_left > 0));
        check("rom_loaded", rom_loaded, m_loaded);
        check("boot_error", boot_error, m_err);
        check("dn_wr", bus.dn_wr, m_dn_wr);
        check("dn_addr", bus.dn_addr, m_dn_addr);
        check("dn_data", bus.dn_data, m_dn_data);
        check("dip_defaults", dip_defaults, m_dip);
`ifdef BOOT_CHECKSUM_EN
        check("checksum", checksum, m_sum);
`else
        check("checksum", checksum, 32'd0);
`endif
    endtask

    // One clock: drive ce, advance the model on the inputs the DUT samples, then compare.
    task automatic cyc();
        if (ce_period > 0) ce_6m = ((tick % ce_period) == ce_period - 1);
        else ce_6m = ($urandom_range(0, 2) == 0);
        tick++;
        model_step();
        @(posedge clk_sys);
        #1;
        model_check();
    endtask

    task automatic dl_begin(input logic [7:0] idx);
        bus.ioctl_index = idx;
        bus.ioctl_downl = 1'b1;
        cyc();
    endtask

    task automatic dl_byte(input logic [24:0] addr, input logic [7:0] data);
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = addr; bus.ioctl_dout = data;
        cyc();
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic dl_end();
        bus.ioctl_downl = 1'b0;
        cyc();
    endtask

    task automatic pulse_user_reset();
        user_reset = 1'b1;
        cyc();
        user_reset = 1'b0;
    endtask

    // Counts ce pulses until core_reset drops; an expired bound leaves core_reset high.
    task automatic wait_release(output int pulses);
        pulses = 0;
        for (int i = 0; i < 400 && core_reset; i++) begin
            cyc();
            if (ce_6m) pulses++;
        end
    endtask

    initial begin
        int p;
        vecs[0] = '{25'd0,     8'h12, 32'hFFFF_FF12};
        vecs[1] = '{25'd4,     8'hAA, 32'hFFFF_FF12};
        vecs[2] = '{25'd1,     8'h34, 32'hFFFF_3412};
        vecs[3] = '{25'd2,     8'h56, 32'hFF56_3412};
        vecs[4] = '{25'h100,   8'h00, 32'hFF56_3412};
        vecs[5] = '{25'd3,     8'h78, 32'h7856_3412};

        reset = 1'b1; ce_6m = 1'b0; user_reset = 1'b0;
        bus.ioctl_downl = 1'b0; bus.ioctl_index = 8'd0; bus.ioctl_wr = 1'b0;
        bus.ioctl_addr = 25'd0; bus.ioctl_dout = 8'd0;
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b0;
        model_reset();

        check("reset core_reset", core_reset, 32'd1);
        check("reset rom_loaded", rom_loaded, 32'd0);
        check("reset boot_error", boot_error, 32'd0);
        check("reset busy", busy, 32'd0);
        check("reset dn_wr", bus.dn_wr, 32'd0);
        check("reset dip", dip_defaults, 32'hFFFF_FFFF);
        check("reset checksum", checksum, 32'd0);

        repeat (100) cyc();
        check("idle core_reset", core_reset, 32'd1);
        check("idle busy", busy, 32'd0);

        // Full image, data = addr[7:0], plus two out-of-range writes that must be dropped.
        n_dnwr = 0;
        dl_begin(8'd0);
        check("dl0 busy", busy, 32'd1);
        for (int a = 0; a < int'(ROM_BYTES); a++) dl_byte(25'(a), 8'(a));
        dl_byte(25'd49152, 8'h5A);
        dl_byte(25'h1FF_FFFF, 8'hA5);
        dl_end();
        check("dn_wr pulse count", n_dnwr, 32'd49152);
        check("valid rom_loaded", rom_loaded, 32'd1);
        check("valid core_reset held", core_reset, 32'd1);
`ifdef BOOT_CHECKSUM_EN
        check("chk dut boot_error", boot_error_c, 32'd1);
        check("chk dut rom_loaded", rom_loaded_c, 32'd0);
        check("chk dut checksum", checksum_c, 32'h1235);
`endif
        wait_release(p);
        check("load hold pulses", p, 32'd16);
        check("load core_reset released", core_reset, 32'd0);

        // DIP vector table through an index-1 download.
        dl_begin(8'd1);
        check("dl1 core_reset", core_reset, 32'd1);
        for (int i = 0; i < 6; i++) begin
            dl_byte(vecs[i].addr, vecs[i].data);
            check($sformatf("dip vec %0d", i), dip_defaults, vecs[i].exp_dip);
        end
        dl_end();
        wait_release(p);
        check("dip hold pulses", p, 32'd16);
        check("dip final", dip_defaults, 32'h7856_3412);

        // User reset from RUN, then a second one at hold pulse 10 restarts the count.
        pulse_user_reset();
        check("ureset core_reset", core_reset, 32'd1);
        p = 0;
        for (int i = 0; i < 200 && p < 10; i++) begin
            cyc();
            if (ce_6m) p++;
        end
        pulse_user_reset();
        check("ureset2 core_reset", core_reset, 32'd1);
        wait_release(p);
        check("ureset restart pulses", p, 32'd16);
        check("ureset core_reset released", core_reset, 32'd0);

        // Randomized traffic with random ce_6m.
        ce_period = 0;
        for (int it = 0; it < 30; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 3) begin
                pulse_user_reset();
            end else if (op < 6) begin
                dl_begin(8'd1);
                for (int j = 0; j < int'($urandom_range(1, 8)); j++)
                    dl_byte(25'($urandom_range(0, 7)), 8'($urandom));
                dl_end();
            end else if (op < 9) begin
                dl_begin(8'($urandom_range(2, 255)));
                for (int j = 0; j < int'($urandom_range(0, 6)); j++)
                    dl_byte(25'($urandom_range(0, 98304)), 8'($urandom));
                dl_end();
            end else begin
                dl_begin(8'd0);
                for (int j = 0; j < int'($urandom_range(1, 200)); j++)
                    dl_byte(25'($urandom_range(0, 98304)), 8'($urandom));
                dl_end();
            end
            repeat ($urandom_range(0, 40)) cyc();
        end

        // Short image: error, and user reset cannot release the core.
        ce_period = 4;
        dl_begin(8'd0);
        for (int a = 0; a < 1000; a++) dl_byte(25'(a), 8'(a));
        dl_end();
        check("short boot_error", boot_error, 32'd1);
        check("short rom_loaded", rom_loaded, 32'd0);
        check("short core_reset", core_reset, 32'd1);
        pulse_user_reset();
        repeat (50) cyc();
        check("error ureset core_reset", core_reset, 32'd1);
        check("error ureset busy", busy, 32'd0);
        check("error ureset boot_error", boot_error, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
